dmem_block_responder: RTL and testbench
=======================================

// Module: dmem_block_responder
// PURPOSE
//  Data-memory responder: the memory end of the core's data interface.
//  Serves word reads/writes (data_address/MemRead/MemWrite/write_size) and
//  256-bit block reads/writes (dBlkRead/dBlkWrite) from an internal
//  word-addressed array, with programmable block latency.
//  Stands in for main memory behind the data cache in RTL-only simulation.
// PARAMETERS
//  ADDR_WIDTH   14  word-address bits; array = 2**ADDR_WIDTH 32-bit words
//  BLK_LATENCY  4   cycles from block request accept to valid (>=1)
// PORTS
//  CLK                    in   1    clock, rising edge
//  RESET                  in   1    asynchronous, active-low reset
//  data_address_2DM       in   32   byte address, word and block ops
//  MemRead_2DM            in   1    word read enable
//  MemWrite_2DM           in   1    word write enable
//  data_write_2DM         in   32   word write data, right-justified
//  data_write_size_2DM    in   2    bytes to write: 1,2,3; 0 = 4
//  data_read_fDM          out  32   word read data
//  dBlkRead               in   1    block read request, level, held
//  dBlkWrite              in   1    block write request, level, held
//  block_write_2DM        in   256  block write data
//  block_read_fDM         out  256  block read data
//  block_read_fDM_valid   out  1    block read complete
//  block_write_fDM_valid  out  1    block write committed
// BEHAVIOUR
//  Addressing: word index = address[ADDR_WIDTH+1:2]; upper bits ignored
//   (wrap). Block base = address with bits [4:0] cleared.
//  Byte order big-endian: byte offset 0 = bits[31:24]. Block word i
//   (base+4i) = bits[255-32i -: 32].
//  Word read: combinational; data_read_fDM = array[idx] when MemRead_2DM,
//   else 32'h0. Word address bits [1:0] ignored.
//  Word write: on CLK edge when MemWrite_2DM. N = size (0 -> 4). Bytes at
//   offsets addr[1:0]..addr[1:0]+N-1 get the low N bytes of data_write,
//   MSB first. Offsets >3 are dropped; no wrap into the next word.
//  MemRead and MemWrite together: write on the edge, read shows old data.
//  Block FSM: IDLE, BUSY, RESP.
//   IDLE: dBlkWrite wins over dBlkRead. On accept edge, latch base, op,
//    and write data (block_write_2DM). Load cnt=BLK_LATENCY-1, go BUSY.
//   BUSY: cnt decrements each edge. If the active request drops, abort
//    (no commit) and go IDLE. At cnt==0 edge: read latches 8 words into
//    block_read_fDM; write commits 8 words to the array. Go RESP.
//   RESP: the matching valid is held high while the request is held.
//    On request low, valid clears on that edge and FSM goes IDLE.
//   Latency: accepted at edge k; valid high after edge k+BLK_LATENCY.
//  Word writes during BUSY are applied immediately. A block read captures
//   array state at the completion edge. A block-write commit on the same
//   edge as a word write to the same word wins.
//  block_read_fDM holds its value until the next read completion.
//  Reset (async, any state): FSM IDLE, cnt 0, both valids 0,
//   block_read_fDM 0, pending write discarded. Array contents not cleared.
// TESTING
//  1 Word write 0xDEADBEEF size 0 @0x100, read @0x100 -> 0xDEADBEEF
//    same cycle.
//  2 Word 0x11223344 @0x200; write 0xAB size 1 @0x202 -> read 0x1122AB44.
//    Then write 0xCDEF size 2 @0x203 -> read 0x1122ABCD (byte 4 dropped).
//  3 Fill 0x400..0x41C with i+1; dBlkRead @0x40C held -> valid after
//    exactly 4 edges; block = {32'h1,...,32'h8}. Drop request -> valid 0
//    next edge.
//  4 dBlkRead and dBlkWrite together @0x600: write serviced first
//    (write_valid only). Then read -> same 256 bits back.
//  5 dBlkWrite dropped after 2 BUSY cycles -> no commit; memory unchanged.
//    Next request accepted normally.
//  6 RESET low while in RESP -> valids and block_read_fDM 0 immediately.
//    Array contents intact after release.

Source files
------------

// File: rtl/dmem_block_responder_if.sv
// Core-to-memory data port: word access signals plus the 256-bit block request/response pair.
// master = core/cache side, slave = memory responder side.
interface dmem_block_responder_if;
  logic [31:0]  data_address_2DM;
  logic         MemRead_2DM;
  logic         MemWrite_2DM;
  logic [31:0]  data_write_2DM;
  logic [1:0]   data_write_size_2DM;
  logic [31:0]  data_read_fDM;
  logic         dBlkRead;
  logic         dBlkWrite;
  logic [255:0] block_write_2DM;
  logic [255:0] block_read_fDM;
  logic         block_read_fDM_valid;
  logic         block_write_fDM_valid;

  modport master (
    output data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM,
           data_write_size_2DM, dBlkRead, dBlkWrite, block_write_2DM,
    input  data_read_fDM, block_read_fDM, block_read_fDM_valid, block_write_fDM_valid
  );

  modport slave (
    input  data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM,
           data_write_size_2DM, dBlkRead, dBlkWrite, block_write_2DM,
    output data_read_fDM, block_read_fDM, block_read_fDM_valid, block_write_fDM_valid
  );
endinterface

// File: rtl/dmem_block_responder.sv
// Data-memory responder: combinational word reads, byte-lane word writes, 256-bit block ops.
// Block valid rises BLK_LATENCY edges after accept; the request is held throughout and dropping it aborts.
module dmem_block_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int BLK_LATENCY = 4
) (
  input logic                   CLK,
  input logic                   RESET,
  dmem_block_responder_if.slave dm
);
  localparam int CNT_W = $clog2(BLK_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLK_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  logic [31:0]           mem [2**ADDR_WIDTH];
  state_t                state, nxt_state;
  logic [CNT_W-1:0]      cnt, nxt_cnt;
  logic                  accept, done, vld_clr, req_act;
  logic                  op_wr_q;
  logic [ADDR_WIDTH-4:0] base_q;
  logic [255:0]          wdata_q, block_read_q;
  logic                  rd_vld_q, wr_vld_q;
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            wr_off, sel;
  logic [2:0]            wr_n;
  logic [31:0]           wr_word;
  logic                  unused_addr_bits;

  assign widx             = dm.data_address_2DM[ADDR_WIDTH+1:2];
  assign wr_off           = dm.data_address_2DM[1:0];
  assign wr_n             = (dm.data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, dm.data_write_size_2DM};
  assign unused_addr_bits = ^dm.data_address_2DM[31:ADDR_WIDTH+2];

  assign dm.data_read_fDM         = dm.MemRead_2DM ? mem[widx] : 32'h0;
  assign dm.block_read_fDM        = block_read_q;
  assign dm.block_read_fDM_valid  = rd_vld_q;
  assign dm.block_write_fDM_valid = wr_vld_q;

  // Lanes past byte 3 are simply never selected, so a straddling write is truncated.
  always_comb begin
    wr_word = mem[widx];
    sel     = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) >= {1'b0, wr_off} && 3'(b) < {1'b0, wr_off} + wr_n) begin
        sel = 2'(wr_n - 3'd1 - (3'(b) - {1'b0, wr_off}));
        wr_word[8*(3-b) +: 8] = dm.data_write_2DM[{sel, 3'b000} +: 8];
      end
    end
  end

  assign req_act = op_wr_q ? dm.dBlkWrite : dm.dBlkRead;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    accept    = 1'b0;
    done      = 1'b0;
    vld_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (dm.dBlkWrite || dm.dBlkRead) begin
          accept    = 1'b1;
          nxt_cnt   = CNT_LOAD;
          nxt_state = BUSY;
        end
      end
      BUSY: begin
        if (!req_act) begin
          nxt_state = IDLE;
        end else if (cnt == '0) begin
          done      = 1'b1;
          nxt_state = RESP;
        end else begin
          nxt_cnt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (!req_act) begin
          vld_clr   = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      op_wr_q      <= 1'b0;
      base_q       <= '0;
      wdata_q      <= '0;
      block_read_q <= '0;
      rd_vld_q     <= 1'b0;
      wr_vld_q     <= 1'b0;
    end else begin
      if (accept) begin
        op_wr_q <= dm.dBlkWrite;
        base_q  <= dm.data_address_2DM[ADDR_WIDTH+1:5];
        wdata_q <= dm.block_write_2DM;
      end
      if (done) begin
        if (op_wr_q) begin
          wr_vld_q <= 1'b1;
        end else begin
          rd_vld_q <= 1'b1;
          for (int i = 0; i < 8; i++) block_read_q[255-32*i -: 32] <= mem[{base_q, 3'(i)}];
        end
      end
      if (vld_clr) begin
        rd_vld_q <= 1'b0;
        wr_vld_q <= 1'b0;
      end
    end
  end

  // Block commit is issued after the word write so it wins on a same-edge collision.
  always_ff @(posedge CLK) begin
    if (dm.MemWrite_2DM) mem[widx] <= wr_word;
    if (done && op_wr_q) begin
      for (int i = 0; i < 8; i++) mem[{base_q, 3'(i)}] <= wdata_q[255-32*i -: 32];
    end
  end
endmodule

// File: tb/tb_dmem_block_responder.sv
// Bench for dmem_block_responder: directed vectors with literal expectations plus a per-cycle reference model.
module tb_dmem_block_responder;
  localparam int AW = 14;
  localparam int L  = 4;

  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_block_responder_if bus ();
  dmem_block_responder #(.ADDR_WIDTH(AW), .BLK_LATENCY(L)) dut (.CLK(CLK), .RESET(RESET), .dm(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  mmem [int];
  bit           m_act, m_op_wr, m_rd_vld, m_wr_vld;
  int           m_base, m_age;
  logic [255:0] m_wdata, m_blk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] sz, input logic [1:0] off);
    int n;
    int pos;
    logic [31:0] w;
    n = (sz == 2'd0) ? 4 : int'(sz);
    w = old;
    for (int k = 0; k < n; k++) begin
      pos = int'(off) + k;
      if (pos <= 3) w[31-8*pos -: 8] = d[8*(n-1-k) +: 8];
    end
    return w;
  endfunction

  task automatic model_step();
    bit   fin_rd, fin_wr, req;
    int   idx, key;
    fin_rd = 1'b0;
    fin_wr = 1'b0;
    if (!RESET) begin
      m_act = 1'b0; m_rd_vld = 1'b0; m_wr_vld = 1'b0; m_blk = '0;
    end else if (!m_act) begin
      if (bus.dBlkWrite || bus.dBlkRead) begin
        m_act   = 1'b1;
        m_op_wr = bus.dBlkWrite;
        m_base  = int'(bus.data_address_2DM[AW+1:5]);
        m_wdata = bus.block_write_2DM;
        m_age   = 0;
      end
    end else begin
      req = m_op_wr ? bus.dBlkWrite : bus.dBlkRead;
      if (!req) begin
        m_act = 1'b0; m_rd_vld = 1'b0; m_wr_vld = 1'b0;
      end else begin
        m_age++;
        if (m_age == L) begin
          if (m_op_wr) fin_wr = 1'b1;
          else         fin_rd = 1'b1;
        end
      end
    end
    if (fin_rd) begin
      for (int i = 0; i < 8; i++) begin
        key = m_base * 8 + i;
        m_blk[255-32*i -: 32] = mmem.exists(key) ? mmem[key] : 32'h0;
      end
      m_rd_vld = 1'b1;
    end
    if (bus.MemWrite_2DM) begin
      idx = int'(bus.data_address_2DM[AW+1:2]);
      if (mmem.exists(idx))
        mmem[idx] = merge(mmem[idx], bus.data_write_2DM, bus.data_write_size_2DM, bus.data_address_2DM[1:0]);
      else if (bus.data_write_size_2DM == 2'd0 && bus.data_address_2DM[1:0] == 2'd0)
        mmem[idx] = bus.data_write_2DM;
    end
    if (fin_wr) begin
      for (int i = 0; i < 8; i++) mmem[m_base * 8 + i] = m_wdata[255-32*i -: 32];
      m_wr_vld = 1'b1;
    end
  endtask

  task automatic compare();
    int idx;
    idx = int'(bus.data_address_2DM[AW+1:2]);
    chk("model_rd_vld", bus.block_read_fDM_valid, m_rd_vld);
    chk("model_wr_vld", bus.block_write_fDM_valid, m_wr_vld);
    chk("model_blk_data", bus.block_read_fDM, m_blk);
    if (!bus.MemRead_2DM)        chk("model_word_idle", bus.data_read_fDM, 32'h0);
    else if (mmem.exists(idx))   chk("model_word_rd", bus.data_read_fDM, mmem[idx]);
  endtask

  always @(posedge CLK) begin
    model_step();
    #1;
    if (RESET) compare();
  end

  // ---------------- drivers ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          output logic [31:0] rd);
    @(negedge CLK);
    bus.data_address_2DM = a; bus.data_write_2DM = d; bus.data_write_size_2DM = s;
    bus.MemWrite_2DM = 1'b1; bus.MemRead_2DM = 1'b1;
    @(posedge CLK); #2;
    rd = bus.data_read_fDM;
    @(negedge CLK);
    bus.MemWrite_2DM = 1'b0; bus.MemRead_2DM = 1'b0;
  endtask

  task automatic rd_word(input logic [31:0] a, output logic [31:0] rd);
    @(negedge CLK);
    bus.data_address_2DM = a; bus.MemRead_2DM = 1'b1;
    @(posedge CLK); #2;
    rd = bus.data_read_fDM;
    @(negedge CLK);
    bus.MemRead_2DM = 1'b0;
  endtask

  // Counts edges from the one that accepts the request up to the one that raises valid.
  task automatic wait_vld(input bit want_wr, output int edges);
    edges = 0;
    do begin
      @(posedge CLK); #2;
      edges++;
    end while (!(want_wr ? bus.block_write_fDM_valid : bus.block_read_fDM_valid) && edges < 40);
  endtask

  task automatic blk_op(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] d,
                        input bit want_wr, output int edges);
    @(negedge CLK);
    bus.data_address_2DM = a; bus.block_write_2DM = d;
    bus.dBlkRead = rd; bus.dBlkWrite = wr;
    wait_vld(want_wr, edges);
  endtask

  task automatic blk_drop();
    @(negedge CLK);
    bus.dBlkRead = 1'b0; bus.dBlkWrite = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [255:0] BLK_1TO8 = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
  localparam logic [255:0] PAT_A    = 256'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3_E0E1E2E3_F0F1F2F3_01234567_89ABCDEF;
  localparam logic [255:0] PAT_Q    = 256'h10000001_20000002_30000003_40000004_50000005_60000006_70000007_80000008;
  localparam logic [255:0] PAT_R    = 256'hFFFF0000_EEEE1111_DDDD2222_CCCC3333_BBBB4444_AAAA5555_99996666_88887777;

  initial begin
    logic [31:0] rd;
    int          edges;
    RESET = 1'b0;
    bus.data_address_2DM = '0; bus.MemRead_2DM = 1'b0; bus.MemWrite_2DM = 1'b0;
    bus.data_write_2DM = '0; bus.data_write_size_2DM = '0;
    bus.dBlkRead = 1'b0; bus.dBlkWrite = 1'b0; bus.block_write_2DM = '0;
    repeat (2) @(negedge CLK);
    chk("reset_rd_vld", bus.block_read_fDM_valid, 1'b0);
    chk("reset_wr_vld", bus.block_write_fDM_valid, 1'b0);
    chk("reset_blk_data", bus.block_read_fDM, 256'h0);
    RESET = 1'b1;

    // 1: full word write, read back in the same cycle
    do_write(32'h100, 32'hDEADBEEF, 2'd0, rd);
    chk("t1_word_rw", rd, 32'hDEADBEEF);

    // 2: byte and straddling half-word writes
    do_write(32'h200, 32'h11223344, 2'd0, rd);
    do_write(32'h202, 32'h000000AB, 2'd1, rd);
    chk("t2_byte_wr", rd, 32'h1122AB44);
    do_write(32'h203, 32'h0000CDEF, 2'd2, rd);
    chk("t2_straddle_wr", rd, 32'h1122ABCD);

    // 3: block read latency and word order
    for (int i = 0; i < 8; i++) do_write(32'h400 + 32'(4 * i), 32'(i + 1), 2'd0, rd);
    blk_op(1'b1, 1'b0, 32'h40C, '0, 1'b0, edges);
    chk("t3_rd_latency", edges, 1 + L);
    chk("t3_rd_data", bus.block_read_fDM, BLK_1TO8);
    blk_drop();
    @(posedge CLK); #2;
    chk("t3_rd_vld_drop", bus.block_read_fDM_valid, 1'b0);

    // 4: simultaneous requests, write has priority, then read back
    blk_op(1'b1, 1'b1, 32'h600, PAT_A, 1'b1, edges);
    chk("t4_wr_latency", edges, 1 + L);
    chk("t4_rd_vld_quiet", bus.block_read_fDM_valid, 1'b0);
    blk_drop();
    @(negedge CLK);
    blk_op(1'b1, 1'b0, 32'h610, '0, 1'b0, edges);
    chk("t4_readback", bus.block_read_fDM, PAT_A);
    blk_drop();

    // 5: aborted block write leaves memory untouched
    @(negedge CLK);
    blk_op(1'b0, 1'b1, 32'h800, PAT_Q, 1'b1, edges);
    blk_drop();
    @(negedge CLK);
    bus.data_address_2DM = 32'h800; bus.block_write_2DM = PAT_R; bus.dBlkWrite = 1'b1;
    repeat (3) @(posedge CLK);
    blk_drop();
    repeat (3) @(posedge CLK);
    #2;
    chk("t5_no_wr_vld", bus.block_write_fDM_valid, 1'b0);
    blk_op(1'b1, 1'b0, 32'h81C, '0, 1'b0, edges);
    chk("t5_next_latency", edges, 1 + L);
    chk("t5_mem_intact", bus.block_read_fDM, PAT_Q);
    blk_drop();

    // 6: asynchronous reset while holding a response
    @(negedge CLK);
    blk_op(1'b1, 1'b0, 32'h400, '0, 1'b0, edges);
    chk("t6_pre_rd_vld", bus.block_read_fDM_valid, 1'b1);
    @(posedge CLK); #3;
    RESET = 1'b0;
    #1;
    chk("t6_rst_rd_vld", bus.block_read_fDM_valid, 1'b0);
    chk("t6_rst_wr_vld", bus.block_write_fDM_valid, 1'b0);
    chk("t6_rst_blk_data", bus.block_read_fDM, 256'h0);
    bus.dBlkRead = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    rd_word(32'h100, rd);
    chk("t6_word_kept_a", rd, 32'hDEADBEEF);
    rd_word(32'h200, rd);
    chk("t6_word_kept_b", rd, 32'h1122ABCD);
    blk_op(1'b1, 1'b0, 32'h400, '0, 1'b0, edges);
    chk("t6_blk_kept", bus.block_read_fDM, BLK_1TO8);
    blk_drop();
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
